// File: rtl/hamming_pkg.sv
// Shared constants for the Hamming(12,8) serial transmitter: code positions,
// the data position table, the transmitter FSM states and the error-inject mask.
package hamming_pkg;

  localparam int unsigned POS_P1 = 1;
  localparam int unsigned POS_P2 = 2;
  localparam int unsigned POS_P4 = 4;
  localparam int unsigned POS_P8 = 8;

  // DATA_POS[i] is the code position carrying payload bit Di.
  localparam int unsigned DATA_POS [1:8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // One-hot at code position pos; 0 and 13..15 give an all-zero mask.
  function automatic logic [1:12] err_mask(input logic [3:0] pos);
    logic [1:12] m;
    m = '0;
    for (int unsigned i = 1; i <= 12; i++) begin
      if (pos == 4'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/hamming_encode.sv
// Combinational even-parity Hamming(12,8) encoder; code[1] is sent first on the line.
module hamming_encode
  import hamming_pkg::*;
(
  input  logic [1:8]  data,
  output logic [1:12] code
);

  always_comb begin
    code = '0;
    for (int unsigned i = 1; i <= 8; i++) begin
      code[DATA_POS[i]] = data[i];
    end
    code[POS_P1] = code[3] ^ code[5] ^ code[7]  ^ code[9]  ^ code[11];
    code[POS_P2] = code[3] ^ code[6] ^ code[7]  ^ code[10] ^ code[11];
    code[POS_P4] = code[5] ^ code[6] ^ code[7]  ^ code[12];
    code[POS_P8] = code[9] ^ code[10] ^ code[11] ^ code[12];
  end

endmodule

// File: rtl/hamming_serial_tx.sv
// Hamming(12,8) serial transmitter: accepts a byte, encodes it (optionally flipping one
// code bit) and sends start bit, code positions 1..12 and a stop bit on tx.
module hamming_serial_tx
  import hamming_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:8]  in_data,
  input  logic [3:0]  in_err,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic [1:12] code_out,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  tx_state_t     state;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [1:12]   enc;
  logic          slot_end;
  logic          stop_next_last;

  hamming_encode u_enc (
    .data (in_data),
    .code (enc)
  );

  assign in_ready       = (state == IDLE) && !rst;
  assign slot_end       = (clk_cnt == LAST);
  assign stop_next_last = ((clk_cnt + ONE) == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      code_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      clk_cnt  <= '0;
      bit_idx  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            code_out <= enc ^ err_mask(in_err);
            tx       <= 1'b0;
            busy     <= 1'b1;
            clk_cnt  <= '0;
            state    <= START;
          end
        end
        START: begin
          if (slot_end) begin
            clk_cnt <= '0;
            bit_idx <= 4'd1;
            tx      <= code_out[1];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + ONE;
          end
        end
        DATA: begin
          if (slot_end) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd12) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
              // With one clock per bit the stop slot is itself the last cycle.
              done    <= (CLKS_PER_BIT == 1);
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= code_out[bit_idx + 4'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + ONE;
          end
        end
        STOP: begin
          if (slot_end) begin
            clk_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + ONE;
            done    <= stop_next_last;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
